lii_gearbox_wrapper: RTL and testbench

LII_GEARBOX_WRAPPER -- requirements
Module: lii_gearbox_wrapper

---
 rtl/lii_gearbox_wrapper.sv | 187 ++++++++++++++++++
 tb/tb_lii_gearbox_wrapper.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_gearbox_wrapper.sv
// Gearbox between a PW-bit LII phy stream and a KW-bit HLS kernel stream:
// unpacks addressed phy beats into kernel words and packs kernel words back into phy beats.
module lii_gearbox_wrapper #(
  parameter int          PW     = 64,
  parameter int          KW     = 16,
  parameter int          DEPTH  = 4,
  parameter logic [7:0]  SRC_ID = 8'h00,
  parameter logic [7:0]  DST_ID = 8'h00,
  localparam int         LANES  = PW / KW
) (
  input  logic             aclk,
  input  logic             arstn,

  input  logic [PW-1:0]    lii_in_tdata,
  input  logic             lii_in_tvalid,
  output logic             lii_in_tready,
  input  logic [7:0]       lii_in_src,
  input  logic [7:0]       lii_in_dst,

  output logic [PW-1:0]    lii_out_tdata,
  output logic             lii_out_tvalid,
  input  logic             lii_out_tready,
  output logic [LANES-1:0] lii_out_tkeep,
  output logic             lii_out_tlast,
  output logic [7:0]       lii_out_src,
  output logic [7:0]       lii_out_dst,

  output logic [KW-1:0]    in_stream_tdata,
  output logic             in_stream_tvalid,
  input  logic             in_stream_tready,

  input  logic [KW-1:0]    out_stream_tdata,
  input  logic             out_stream_tvalid,
  output logic             out_stream_tready,
  input  logic             out_stream_tlast,

  output logic             ce
);

  localparam int               LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int               AW        = $clog2(DEPTH);
  localparam int               CW        = AW + 1;
  localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0]    FULL      = CW'(DEPTH);

  // Valid/ready: a beat moves on a rising aclk edge when tvalid and tready are
  // both high; a producer holds its data stable until that edge.

  // run is low during reset and rises on the first edge afterwards, so every
  // ready/enable output is forced low while arstn is asserted.
  logic run;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) run <= 1'b0;
    else        run <= 1'b1;
  end

  // ---------------------------------------------------------------- unpack
  logic [LANES-1:0][KW-1:0] hold_lanes;
  logic                     hold_valid;
  logic [LW-1:0]            idx;
  logic                     in_fire;
  logic                     in_keep;
  logic                     k_fire;
  logic                     idx_last;

  assign idx_last = (idx == LAST_LANE);
  assign in_fire  = lii_in_tvalid & lii_in_tready;
  assign in_keep  = in_fire & (lii_in_dst == SRC_ID);
  assign k_fire   = hold_valid & in_stream_tready;

  assign lii_in_tready    = run & (~hold_valid | (in_stream_tready & idx_last));
  assign in_stream_tvalid = hold_valid;
  assign in_stream_tdata  = hold_lanes[idx];

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      hold_lanes <= '0;
      hold_valid <= 1'b0;
      idx        <= '0;
    end else if (in_keep) begin
      hold_lanes <= lii_in_tdata;
      hold_valid <= 1'b1;
      idx        <= '0;
    end else if (k_fire) begin
      if (idx_last) begin
        hold_valid <= 1'b0;
        idx        <= '0;
      end else begin
        idx <= idx + LW'(1);
      end
    end
  end

  // ------------------------------------------------------------------ pack
  logic [LANES-1:0][KW-1:0] acc;
  logic [LW-1:0]            cnt;
  logic [LANES-1:0][KW-1:0] push_lanes;
  logic [LANES-1:0]         push_keep;
  logic                     o_fire;
  logic                     o_done;

  assign o_fire = out_stream_tvalid & out_stream_tready;
  assign o_done = o_fire & ((cnt == LAST_LANE) | out_stream_tlast);

  // The completing word goes straight into the pushed beat; lanes above it are
  // still zero because the accumulator is cleared on every push.
  always_comb begin
    push_lanes      = acc;
    push_lanes[cnt] = out_stream_tdata;
    push_keep       = '0;
    for (int i = 0; i < LANES; i++) begin
      push_keep[i] = (i <= int'(cnt));
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      acc <= '0;
      cnt <= '0;
    end else if (o_fire) begin
      if (o_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc[cnt] <= out_stream_tdata;
        cnt      <= cnt + LW'(1);
      end
    end
  end

  // ------------------------------------------------------------------ fifo
  logic [PW-1:0]    mem_data [DEPTH];
  logic [LANES-1:0] mem_keep [DEPTH];
  logic             mem_last [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             not_full;
  logic             push;
  logic             pop;

  // Room is judged on the registered count only, so a pop never frees a slot
  // for an accept on the same edge.
  assign not_full          = (count < FULL);
  assign out_stream_tready = run & not_full;
  assign ce                = run & not_full;

  assign push = o_done;
  assign pop  = lii_out_tvalid & lii_out_tready;

  assign lii_out_tvalid = (count != '0);
  assign lii_out_tdata  = mem_data[rd_ptr];
  assign lii_out_tkeep  = mem_keep[rd_ptr];
  assign lii_out_tlast  = mem_last[rd_ptr];
  assign lii_out_src    = SRC_ID;
  assign lii_out_dst    = DST_ID;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_lanes;
      mem_keep[wr_ptr] <= push_keep;
      mem_last[wr_ptr] <= out_stream_tlast;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The source tag of an incoming beat carries no meaning for this node.
  logic unused_src;
  assign unused_src = ^lii_in_src;

endmodule

// File: tb/tb_lii_gearbox_wrapper.sv
// Bench for lii_gearbox_wrapper: reset checks, a pack vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_lii_gearbox_wrapper;
  localparam int         PW    = 64;
  localparam int         KW    = 16;
  localparam int         DEPTH = 4;
  localparam int         LANES = PW / KW;
  localparam logic [7:0] SRC   = 8'h03;
  localparam logic [7:0] DST   = 8'h0A;

  logic             aclk = 1'b0;
  logic             arstn;
  logic [PW-1:0]    lii_in_tdata;
  logic             lii_in_tvalid;
  logic             lii_in_tready;
  logic [7:0]       lii_in_src;
  logic [7:0]       lii_in_dst;
  logic [PW-1:0]    lii_out_tdata;
  logic             lii_out_tvalid;
  logic             lii_out_tready;
  logic [LANES-1:0] lii_out_tkeep;
  logic             lii_out_tlast;
  logic [7:0]       lii_out_src;
  logic [7:0]       lii_out_dst;
  logic [KW-1:0]    in_stream_tdata;
  logic             in_stream_tvalid;
  logic             in_stream_tready;
  logic [KW-1:0]    out_stream_tdata;
  logic             out_stream_tvalid;
  logic             out_stream_tready;
  logic             out_stream_tlast;
  logic             ce;

  lii_gearbox_wrapper #(
    .PW(PW), .KW(KW), .DEPTH(DEPTH), .SRC_ID(SRC), .DST_ID(DST)
  ) dut (
    .aclk(aclk), .arstn(arstn),
    .lii_in_tdata(lii_in_tdata), .lii_in_tvalid(lii_in_tvalid),
    .lii_in_tready(lii_in_tready), .lii_in_src(lii_in_src), .lii_in_dst(lii_in_dst),
    .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid),
    .lii_out_tready(lii_out_tready), .lii_out_tkeep(lii_out_tkeep),
    .lii_out_tlast(lii_out_tlast), .lii_out_src(lii_out_src), .lii_out_dst(lii_out_dst),
    .in_stream_tdata(in_stream_tdata), .in_stream_tvalid(in_stream_tvalid),
    .in_stream_tready(in_stream_tready),
    .out_stream_tdata(out_stream_tdata), .out_stream_tvalid(out_stream_tvalid),
    .out_stream_tready(out_stream_tready), .out_stream_tlast(out_stream_tlast),
    .ce(ce)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ------------------------------------------------------------- scoreboard
  int checks = 0;
  int passed = 0;

  logic [KW-1:0]        exp_q[$];     // kernel words expected on in_stream
  logic [PW+LANES:0]    beat_q[$];    // {data, keep, last} expected on lii_out
  logic [KW-1:0]        part_q[$];    // kernel words not yet forming a beat

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_word(input logic [KW-1:0] w, input logic last);
    out_stream_tvalid = 1'b1;
    out_stream_tdata  = w;
    out_stream_tlast  = last;
    tick();
    out_stream_tvalid = 1'b0;
    out_stream_tlast  = 1'b0;
  endtask

  task automatic check_beat(input string name, input logic [PW-1:0] d,
                            input logic [LANES-1:0] k, input logic l);
    check({name, " valid"}, lii_out_tvalid, 1'b1);
    check({name, " data"},  lii_out_tdata,  d);
    check({name, " keep"},  lii_out_tkeep,  k);
    check({name, " last"},  lii_out_tlast,  l);
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    int               n;
    logic [KW-1:0]    w [4];
    logic [3:0]       tl;
    logic [PW-1:0]    d;
    logic [LANES-1:0] k;
    logic             l;
  } pack_vec_t;

  pack_vec_t vecs [4];

  // -------------------------------------------------------------- random run
  // The model works purely on transfers: accepted addressed beats become four
  // expected kernel words; accepted kernel words group into beats of up to
  // four words ending at a full group or tlast.
  task automatic model_pack(input logic [KW-1:0] w, input logic last);
    logic [PW-1:0]    d;
    logic [LANES-1:0] k;
    part_q.push_back(w);
    if (part_q.size() == LANES || last) begin
      d = '0;
      for (int j = 0; j < part_q.size(); j++) d[j*KW +: KW] = part_q[j];
      k = LANES'((1 << part_q.size()) - 1);
      beat_q.push_back({d, k, last});
      part_q.delete();
    end
  endtask

  task automatic random_run(input int cycles, input bit gen);
    bit acc_in  = 1'b0;
    bit acc_out = 1'b0;
    logic [KW-1:0] w;
    for (int c = 0; c < cycles; c++) begin
      @(posedge aclk);
      #1;
      if (!lii_in_tvalid || acc_in) begin
        lii_in_tvalid = gen && ($urandom_range(0, 2) != 0);
        lii_in_tdata  = {$urandom, $urandom};
        lii_in_src    = 8'($urandom);
        lii_in_dst    = ($urandom_range(0, 3) != 0) ? SRC : (8'h10 | 8'($urandom_range(0, 15)));
      end
      if (!out_stream_tvalid || acc_out) begin
        out_stream_tvalid = gen && ($urandom_range(0, 2) != 0);
        out_stream_tdata  = 16'($urandom);
        out_stream_tlast  = ($urandom_range(0, 4) == 0);
      end
      in_stream_tready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      lii_out_tready   = gen ? ($urandom_range(0, 2) != 0) : 1'b1;
      acc_in  = 1'b0;
      acc_out = 1'b0;

      @(negedge aclk);
      check("rnd out_stream_tready", out_stream_tready, beat_q.size() < DEPTH);
      check("rnd ce", ce, beat_q.size() < DEPTH);
      check("rnd lii_out_tvalid", lii_out_tvalid, beat_q.size() != 0);
      if (lii_in_tvalid && lii_in_tready) begin
        acc_in = 1'b1;
        if (lii_in_dst == SRC)
          for (int j = 0; j < LANES; j++) exp_q.push_back(lii_in_tdata[j*KW +: KW]);
      end
      if (in_stream_tvalid && in_stream_tready) begin
        if (exp_q.size() == 0) check("rnd unexpected kernel word", 1'b1, 1'b0);
        else begin
          w = exp_q.pop_front();
          check("rnd kernel word", in_stream_tdata, w);
        end
      end
      if (lii_out_tvalid && lii_out_tready) begin
        if (beat_q.size() == 0) check("rnd unexpected out beat", 1'b1, 1'b0);
        else check("rnd out beat", {lii_out_tdata, lii_out_tkeep, lii_out_tlast}, beat_q.pop_front());
      end
      if (out_stream_tvalid && out_stream_tready) begin
        acc_out = 1'b1;
        model_pack(out_stream_tdata, out_stream_tlast);
      end
    end
  endtask

  // -------------------------------------------------------------- main test
  initial begin
    vecs[0] = '{n: 4, w: '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD}, tl: 4'b0000,
                d: 64'hDDDD_CCCC_BBBB_AAAA, k: 4'hF, l: 1'b0};
    vecs[1] = '{n: 2, w: '{16'h0001, 16'h0002, 16'h0, 16'h0}, tl: 4'b0010,
                d: 64'h0000_0000_0002_0001, k: 4'h3, l: 1'b1};
    vecs[2] = '{n: 1, w: '{16'h5A5A, 16'h0, 16'h0, 16'h0}, tl: 4'b0001,
                d: 64'h0000_0000_0000_5A5A, k: 4'h1, l: 1'b1};
    vecs[3] = '{n: 4, w: '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, tl: 4'b1000,
                d: 64'hDEF0_9ABC_5678_1234, k: 4'hF, l: 1'b1};

    arstn = 1'b0;
    lii_in_tdata = '0; lii_in_tvalid = 1'b0; lii_in_src = '0; lii_in_dst = '0;
    lii_out_tready = 1'b0; in_stream_tready = 1'b0;
    out_stream_tdata = '0; out_stream_tvalid = 1'b0; out_stream_tlast = 1'b0;

    // Reset values, then first edge after release.
    #1;
    check("rst lii_in_tready", lii_in_tready, 1'b0);
    check("rst in_stream_tvalid", in_stream_tvalid, 1'b0);
    check("rst lii_out_tvalid", lii_out_tvalid, 1'b0);
    check("rst out_stream_tready", out_stream_tready, 1'b0);
    check("rst ce", ce, 1'b0);
    tick();
    arstn = 1'b1;
    tick();
    check("post-rst lii_in_tready", lii_in_tready, 1'b1);
    check("post-rst out_stream_tready", out_stream_tready, 1'b1);
    check("post-rst ce", ce, 1'b1);
    check("post-rst lii_out_tvalid", lii_out_tvalid, 1'b0);
    check("post-rst in_stream_tvalid", in_stream_tvalid, 1'b0);

    // Pack vector table.
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        check($sformatf("vec%0d ready w%0d", v, i), out_stream_tready, 1'b1);
        send_word(vecs[v].w[i], vecs[v].tl[i]);
      end
      check_beat($sformatf("vec%0d", v), vecs[v].d, vecs[v].k, vecs[v].l);
      check($sformatf("vec%0d src", v), lii_out_src, SRC);
      check($sformatf("vec%0d dst", v), lii_out_dst, DST);
      lii_out_tready = 1'b1;
      tick();
      lii_out_tready = 1'b0;
      check($sformatf("vec%0d drained", v), lii_out_tvalid, 1'b0);
    end

    // Unpack with a back-to-back second beat.
    in_stream_tready = 1'b1;
    lii_in_tvalid = 1'b1;
    lii_in_tdata  = 64'h4444_3333_2222_1111;
    lii_in_dst    = SRC;
    check("unpack ready idle", lii_in_tready, 1'b1);
    tick();
    lii_in_tdata = 64'h8888_7777_6666_5555;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("unpack valid %0d", i), in_stream_tvalid, 1'b1);
      check($sformatf("unpack word %0d", i), in_stream_tdata, 16'(16'h1111 * (i + 1)));
      if (i < 4) check($sformatf("unpack in ready %0d", i), lii_in_tready, (i == 3));
      tick();
      if (i == 3) lii_in_tvalid = 1'b0;
    end
    check("unpack idle", in_stream_tvalid, 1'b0);

    // Filtered beat: accepted, no kernel words.
    lii_in_tvalid = 1'b1;
    lii_in_tdata  = 64'hDEAD_BEEF_CAFE_F00D;
    lii_in_dst    = 8'h05;
    check("filter ready", lii_in_tready, 1'b1);
    tick();
    lii_in_tvalid = 1'b0;
    check("filter no word", in_stream_tvalid, 1'b0);
    tick();
    check("filter no word later", in_stream_tvalid, 1'b0);
    in_stream_tready = 1'b0;

    // Backpressure: four beats fill the FIFO and stall the kernel.
    lii_out_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("bp ready w%0d", i), out_stream_tready, 1'b1);
      send_word(16'(16'h1000 + i), 1'b0);
    end
    check("bp full tready", out_stream_tready, 1'b0);
    check("bp full ce", ce, 1'b0);
    tick();
    check("bp hold ce", ce, 1'b0);
    lii_out_tready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check_beat($sformatf("bp beat%0d", b),
                 {16'(16'h1003 + 4*b), 16'(16'h1002 + 4*b), 16'(16'h1001 + 4*b), 16'(16'h1000 + 4*b)},
                 4'hF, 1'b0);
      if (b == 0) check("bp ce before pop", ce, 1'b0);
      tick();
      if (b == 0) check("bp ce after pop", ce, 1'b1);
    end
    lii_out_tready = 1'b0;
    check("bp drained", lii_out_tvalid, 1'b0);

    // Reset mid-packet discards the partial accumulator.
    send_word(16'h0AA1, 1'b0);
    send_word(16'h0AA2, 1'b0);
    arstn = 1'b0;
    #1;
    check("midrst out_stream_tready", out_stream_tready, 1'b0);
    check("midrst ce", ce, 1'b0);
    check("midrst lii_out_tvalid", lii_out_tvalid, 1'b0);
    tick();
    arstn = 1'b1;
    tick();
    check("midrst released ready", out_stream_tready, 1'b1);
    check("midrst no beat", lii_out_tvalid, 1'b0);
    for (int i = 0; i < 4; i++) send_word(16'(16'hB001 + i), 1'b0);
    check_beat("midrst clean", 64'hB004_B003_B002_B001, 4'hF, 1'b0);
    lii_out_tready = 1'b1;
    tick();
    lii_out_tready = 1'b0;
    check("midrst drained", lii_out_tvalid, 1'b0);

    // Randomized traffic against the model, then drain.
    random_run(2000, 1'b1);
    random_run(40, 1'b0);
    lii_in_tvalid = 1'b0;
    out_stream_tvalid = 1'b0;
    check("end kernel queue empty", exp_q.size(), 0);
    check("end beat queue empty", beat_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
